key_debounce: RTL
=================

# key_debounce

Upstream input stage for the menu/LCD controller: synchronizes and debounces the four board push-buttons (up, down, select, back) and converts each press into a single-cycle pulse. Its key_press outputs drive the controller's sobe/desce/selec/volta inputs directly, so the controller sees exactly one event per physical press. The block also offers optional auto-repeat on the up/down keys for list scrolling.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000: cycles from the press pulse to the first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000: cycles between later auto-repeat pulses (100 ms).
- Clock  in  1  50 MHz system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- KEY_n  in  4  raw buttons, active-low, asynchronous to Clock; bit 0 up (sobe), 1 down (desce), 2 select (selec), 3 back (volta).
- key_press  out  4  one-cycle active-high press pulse per key, plus repeat pulses on bits 0/1 when enabled.
- key_level  out  4  debounced key state, active-high (1 = held).

## Operation
- Per key, two-flop synchronizer sync1→sync2; reset value 1 (released).
- Per key, registered stable state (active-low) with a debounce counter of $clog2(DEBOUNCE_CYCLES) bits.
  - sync2 == stable: counter cleared to 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter +1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count; no partial credit.
- key_level = ~stable, registered.
- key_press[i] is registered high for exactly one cycle when stable[i] goes 1→0. Release (0→1) never pulses.
- Keys are independent. Simultaneous presses give simultaneous pulses; the block does no arbitration.
- Reset values: key_press = 0, key_level = 0, counters = 0, stable = 1, sync = 1.
- Reset asserted mid-debounce or mid-repeat discards all state. A key held through reset release is seen as a new press and pulses after the normal debounce latency.

## Timing
- Let edge k be the first rising edge at which sync1 samples KEY_n[i] low, with the input held low afterwards.
  - sync2 goes low at edge k+1.
  - The counter increments at edges k+2 through k+D, where D = DEBOUNCE_CYCLES.
  - stable flips and key_press[i] rises at edge k+1+D.
  - key_press[i] falls at edge k+2+D.
- Release is symmetric: key_level falls at edge k'+1+D after the first sampled high at edge k'.
- Minimum press-to-press spacing is 2·D+2 cycles. Faster toggling is filtered out.

## Configuration
- KEY_AUTOREPEAT_EN defined: keys 0 and 1 each have a repeat counter, cleared on the press pulse and counting while key_level is 1.
  - First extra pulse at REPEAT_DELAY cycles after the press pulse.
  - Further pulses every REPEAT_PERIOD cycles while the key is held.
  - Release clears the counter immediately; no pulse is issued on the release cycle.
  - Keys 2 and 3 never repeat.
- KEY_AUTOREPEAT_EN undefined: no repeat logic is synthesized, and every key pulses exactly once per accepted press.

## Test plan
Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset then idle with KEY_n=4'hF: key_press=0 and key_level=0 for 100 cycles.
- KEY_n[2] driven low and held from edge k: a single key_press[2] pulse at edge k+5, key_level[2]=1 from k+5, and no further pulses for 50 cycles.
- KEY_n[0] bounced low/high with 3-cycle phases for 30 cycles, then held high: no pulse and key_level[0] stays 0.
- KEY_n[1] and KEY_n[3] falling on the same edge: key_press=4'b1010 for exactly one cycle.
- KEY_AUTOREPEAT_EN defined, KEY_n[0] held 40 cycles after its press pulse at cycle P: pulses at P, P+10, P+13, P+16, … Release is followed by no pulse. With the macro undefined, only the pulse at P appears.
- Reset_n pulsed low 2 cycles while KEY_n[1] is held mid-debounce: outputs go to 0 immediately, then key_press[1] pulses 5 cycles after the first post-reset sample edge.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button front end: sync, debounce and one-shot press pulses for four keys.
// Optional auto-repeat on keys 0/1 is built when KEY_AUTOREPEAT_EN is defined.

module key_debounce_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          REPEAT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o,
    output logic level_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, press_q, press_d;
    logic          flip, release_evt, rpt_fire;

    // Any mismatch cycle that is not a run of DEBOUNCE_CYCLES restarts from zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        flip     = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                flip     = 1'b1;
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign release_evt = flip & sync2_q;
    assign press_d     = (flip & ~sync2_q) | rpt_fire;

`ifdef KEY_AUTOREPEAT_EN
    if (REPEAT) begin : g_rpt
        localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned RW   = $clog2(RMAX + 1);
        logic [RW-1:0] rcnt_q, rcnt_d, target;
        logic          armed_q, armed_d, fire;

        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; release wins over a due pulse.
        always_comb begin
            rcnt_d  = '0;
            armed_d = 1'b0;
            fire    = 1'b0;
            target  = armed_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
            if (level_q && !release_evt) begin
                armed_d = armed_q;
                if (rcnt_q == target) begin
                    fire    = 1'b1;
                    armed_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rcnt_q  <= '0;
                armed_q <= 1'b0;
            end else begin
                rcnt_q  <= rcnt_d;
                armed_q <= armed_d;
            end
        end

        assign rpt_fire = fire;
    end else begin : g_no_rpt
        logic [31:0] unused_rpt_cfg;
        assign unused_rpt_cfg = REPEAT_DELAY ^ REPEAT_PERIOD ^ {31'b0, release_evt};
        assign rpt_fire       = 1'b0;
    end
`else
    logic [31:0] unused_rpt_cfg;
    assign unused_rpt_cfg = REPEAT_DELAY ^ REPEAT_PERIOD ^ {30'b0, REPEAT, release_evt};
    assign rpt_fire       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            level_q  <= ~stable_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;
    assign level_o = level_q;
endmodule

module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] KEY_n,
    output logic [3:0] key_press,
    output logic [3:0] key_level
);
    // Keys 0/1 (up/down) are the only ones eligible for auto-repeat.
    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT         (i < 2)
        ) u_lane (
            .clk_i  (Clock),
            .rst_n_i(Reset_n),
            .key_n_i(KEY_n[i]),
            .press_o(key_press[i]),
            .level_o(key_level[i])
        );
    end
endmodule
